// File: rtl/plugboard_pkg.sv
// Shared types for the programmable plugboard: config opcodes, FSM states and the LUT entry.
package plugboard_pkg;

    localparam int PB_ALPHABET_LEN = 26;
    localparam int PB_PORTLEN      = 5;

    typedef enum logic [1:0] {
        OP_PLUG   = 2'b00,
        OP_UNPLUG = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } cfg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WR_A,
        ST_WR_B,
        ST_CLR
    } pb_state_e;

    typedef struct packed {
        logic                  plugged;
        logic [PB_PORTLEN-1:0] partner;
    } lut_entry_t;

endpackage

// File: rtl/plugboard_lut.sv
// Plugboard wiring table: one synchronous write port, combinational read ports.
// PLUGBOARD_READBACK_EN adds a fourth read port for external readback.
module plugboard_lut
    import plugboard_pkg::*;
#(
    parameter int ALPHABET_LEN = PB_ALPHABET_LEN,
    parameter int PORTLEN      = PB_PORTLEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr_en,
    input  logic [PORTLEN-1:0] i_wr_addr,
    input  lut_entry_t         i_wr_data,
    input  logic [PORTLEN-1:0] i_xl_addr,
    output lut_entry_t         o_xl_data,
    input  logic [PORTLEN-1:0] i_chk_a_addr,
    output lut_entry_t         o_chk_a_data,
    input  logic [PORTLEN-1:0] i_chk_b_addr,
`ifdef PLUGBOARD_READBACK_EN
    input  logic [PORTLEN-1:0] i_bk_addr,
    output lut_entry_t         o_bk_data,
`endif
    output logic               o_chk_b_plugged
);

    localparam logic [PORTLEN:0] ALEN_W = (PORTLEN + 1)'(ALPHABET_LEN);
`ifdef PLUGBOARD_READBACK_EN
    localparam int NRD = 4;
`else
    localparam int NRD = 3;
`endif

    lut_entry_t         r_mem [ALPHABET_LEN];
    logic [PORTLEN-1:0] w_rd_addr [NRD];
    lut_entry_t         w_rd_data [NRD];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ALPHABET_LEN; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && ({1'b0, i_wr_addr} < ALEN_W)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Out-of-alphabet addresses read as an unplugged, zero entry.
    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            assign w_rd_data[gi] = ({1'b0, w_rd_addr[gi]} < ALEN_W) ? r_mem[w_rd_addr[gi]] : '0;
        end
    endgenerate

    assign w_rd_addr[0]    = i_xl_addr;
    assign w_rd_addr[1]    = i_chk_a_addr;
    assign w_rd_addr[2]    = i_chk_b_addr;
    assign o_xl_data       = w_rd_data[0];
    assign o_chk_a_data    = w_rd_data[1];
    assign o_chk_b_plugged = w_rd_data[2].plugged;
`ifdef PLUGBOARD_READBACK_EN
    assign w_rd_addr[3]    = i_bk_addr;
    assign o_bk_data       = w_rd_data[3];
`endif

endmodule

// File: rtl/plugboard_prog.sv
// Runtime-programmable plugboard: config FSM keeps the LUT symmetric, letters pass a 1-cycle stage.
// PLUGBOARD_READBACK_EN adds rd_addr/rd_data for combinational LUT readback.
module plugboard_prog
    import plugboard_pkg::*;
#(
    parameter int ALPHABET_LEN = 26,
    parameter int PORTLEN      = 5,
    parameter int MAX_CABLES   = 10,
    parameter int CNTW         = $clog2(MAX_CABLES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_op,
    input  logic [PORTLEN-1:0] cfg_a,
    input  logic [PORTLEN-1:0] cfg_b,
    output logic               cfg_done,
    output logic               cfg_err,
    output logic [CNTW-1:0]    cable_count,
`ifdef PLUGBOARD_READBACK_EN
    input  logic [PORTLEN-1:0] rd_addr,
    output logic [PORTLEN:0]   rd_data,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PORTLEN-1:0] in_letter,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PORTLEN-1:0] out_letter,
    output logic               out_error
);

`ifndef SYNTHESIS
    if (PORTLEN != $clog2(ALPHABET_LEN) || PORTLEN != PB_PORTLEN) begin : g_portlen_chk
        $error("plugboard_prog: PORTLEN must equal $clog2(ALPHABET_LEN) and PB_PORTLEN");
    end
`endif

    localparam logic [PORTLEN:0]   ALEN_W   = (PORTLEN + 1)'(ALPHABET_LEN);
    localparam logic [PORTLEN-1:0] LAST_IDX = PORTLEN'(ALPHABET_LEN - 1);
    localparam logic [CNTW-1:0]    MAX_CNT  = CNTW'(MAX_CABLES);

    pb_state_e          r_state;
    cfg_op_e            r_op;
    logic [PORTLEN-1:0] r_a;
    logic [PORTLEN-1:0] r_b;
    logic [PORTLEN-1:0] r_clr_idx;
    logic [CNTW-1:0]    r_count;
    logic               r_cfg_done;
    logic               r_cfg_err;
    logic               r_out_valid;
    logic [PORTLEN-1:0] r_out_letter;
    logic               r_out_error;

    lut_entry_t         w_xl;
    lut_entry_t         w_chk_a;
    logic               w_chk_b_plugged;
    logic               w_wr_en;
    logic [PORTLEN-1:0] w_wr_addr;
    lut_entry_t         w_wr_data;
    logic               w_a_legal;
    logic               w_b_legal;
    logic               w_in_legal;
    logic               w_chk_bad;
    logic               w_cfg_fire;
    logic               w_in_fire;
`ifdef PLUGBOARD_READBACK_EN
    lut_entry_t         w_bk_data;
`endif

    plugboard_lut #(
        .ALPHABET_LEN (ALPHABET_LEN),
        .PORTLEN      (PORTLEN)
    ) u_lut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_wr_en         (w_wr_en),
        .i_wr_addr       (w_wr_addr),
        .i_wr_data       (w_wr_data),
        .i_xl_addr       (in_letter),
        .o_xl_data       (w_xl),
        .i_chk_a_addr    (r_a),
        .o_chk_a_data    (w_chk_a),
        .i_chk_b_addr    (r_b),
`ifdef PLUGBOARD_READBACK_EN
        .i_bk_addr       (rd_addr),
        .o_bk_data       (w_bk_data),
`endif
        .o_chk_b_plugged (w_chk_b_plugged)
    );

`ifdef PLUGBOARD_READBACK_EN
    assign rd_data = w_bk_data;
`endif

    assign w_a_legal  = {1'b0, r_a} < ALEN_W;
    assign w_b_legal  = {1'b0, r_b} < ALEN_W;
    assign w_in_legal = {1'b0, in_letter} < ALEN_W;

    // Config has priority: a pending cfg_valid in IDLE blocks new letters.
    assign cfg_ready  = (r_state == ST_IDLE);
    assign in_ready   = cfg_ready && !cfg_valid && (!r_out_valid || out_ready);
    assign w_cfg_fire = cfg_valid && cfg_ready;
    assign w_in_fire  = in_valid && in_ready;

    always_comb begin
        w_chk_bad = 1'b1;
        case (r_op)
            OP_PLUG:   w_chk_bad = (r_a == r_b) || !w_a_legal || !w_b_legal ||
                                   w_chk_a.plugged || w_chk_b_plugged || (r_count == MAX_CNT);
            OP_UNPLUG: w_chk_bad = !w_a_legal || !w_chk_a.plugged;
            OP_CLEAR:  w_chk_bad = 1'b0;
            default:   w_chk_bad = 1'b1;
        endcase
    end

    // For UNPLUG, r_b holds the partner captured during CHECK; both ends are written as zero.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_a;
        w_wr_data = '0;
        case (r_state)
            ST_WR_A: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_a;
                if (r_op == OP_PLUG) w_wr_data = {1'b1, r_b};
            end
            ST_WR_B: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_b;
                if (r_op == OP_PLUG) w_wr_data = {1'b1, r_a};
            end
            ST_CLR: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_clr_idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_PLUG;
            r_a        <= '0;
            r_b        <= '0;
            r_clr_idx  <= '0;
            r_count    <= '0;
            r_cfg_done <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_done <= 1'b0;
            r_cfg_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_fire) begin
                        r_op      <= cfg_op_e'(cfg_op);
                        r_a       <= cfg_a;
                        r_b       <= cfg_b;
                        r_clr_idx <= '0;
                        r_state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_chk_bad) begin
                        r_cfg_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (r_op == OP_CLEAR) begin
                        r_state <= ST_CLR;
                    end else begin
                        if (r_op == OP_UNPLUG) r_b <= w_chk_a.partner;
                        r_state <= ST_WR_A;
                    end
                end
                ST_WR_A: r_state <= ST_WR_B;
                ST_WR_B: begin
                    r_count    <= (r_op == OP_PLUG) ? r_count + CNTW'(1) : r_count - CNTW'(1);
                    r_cfg_done <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                ST_CLR: begin
                    if (r_clr_idx == LAST_IDX) begin
                        r_count    <= '0;
                        r_cfg_done <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_clr_idx <= r_clr_idx + PORTLEN'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output holds under backpressure; LUT writes only happen outside IDLE so never race an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_letter <= '0;
            r_out_error  <= 1'b0;
        end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            if (!w_in_legal) begin
                r_out_error  <= 1'b1;
                r_out_letter <= '0;
            end else begin
                r_out_error  <= 1'b0;
                r_out_letter <= w_xl.plugged ? w_xl.partner : in_letter;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign cable_count = r_count;
    assign cfg_done    = r_cfg_done;
    assign cfg_err     = r_cfg_err;
    assign out_valid   = r_out_valid;
    assign out_letter  = r_out_letter;
    assign out_error   = r_out_error;

endmodule

// File: tb/tb_plugboard_prog.sv
// Scoreboard bench for plugboard_prog: reference wiring model, config latency and backpressure checks.
module tb_plugboard_prog;

    localparam int AL = 26;
    localparam int PL = 5;
    localparam int MC = 10;
    localparam int CW = $clog2(MC + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_op = 2'b00;
    logic [PL-1:0] cfg_a = '0;
    logic [PL-1:0] cfg_b = '0;
    logic          cfg_done;
    logic          cfg_err;
    logic [CW-1:0] cable_count;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PL-1:0] in_letter = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PL-1:0] out_letter;
    logic          out_error;
`ifdef PLUGBOARD_READBACK_EN
    logic [PL-1:0] rd_addr = '0;
    logic [PL:0]   rd_data;
`endif

    always #5 clk = ~clk;

    plugboard_prog #(
        .ALPHABET_LEN (AL),
        .PORTLEN      (PL),
        .MAX_CABLES   (MC),
        .CNTW         (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_op      (cfg_op),
        .cfg_a       (cfg_a),
        .cfg_b       (cfg_b),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .cable_count (cable_count),
`ifdef PLUGBOARD_READBACK_EN
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_letter   (in_letter),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_letter  (out_letter),
        .out_error   (out_error)
    );

    typedef struct {
        int in;
        int letter;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   model[AL];
    int   exp_cnt = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int l);
        exp_t e;
        e.in = l;
        if (l >= AL) begin
            e.letter = 0;
            e.err    = 1;
        end else begin
            e.letter = model[l];
            e.err    = 0;
        end
        return e;
    endfunction

    // Output monitor: one line per translated letter, compared against the scoreboard head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious out_valid", 32'(out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                $display("xlate in=%0d out=%0d err=%0d", e.in, out_letter, out_error);
                check_eq($sformatf("xlate %0d letter", e.in), 32'(out_letter), e.letter);
                check_eq($sformatf("xlate %0d error", e.in), 32'(out_error), e.err);
            end
        end
    end

    task automatic send_list(input string tag, input int ls[$]);
        int stall;
        stall = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        foreach (ls[i]) begin
            in_letter = PL'(ls[i]);
            @(negedge clk);
            while (!in_ready && stall < 50) begin
                stall++;
                @(negedge clk);
            end
            exp_q.push_back(mk_exp(ls[i]));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq({tag, " stall cycles"}, stall, 0);
    endtask

    task automatic cfg_run(input string tag, input int op, input int a, input int b,
                           input bit exp_ok, input int exp_lat);
        int  n;
        int  p;
        bit  got_done;
        bit  got_err;
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_op    = 2'(op);
        cfg_a     = PL'(a);
        cfg_b     = PL'(b);
        @(negedge clk);
        check_eq({tag, " cfg_ready"}, 32'(cfg_ready), 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        n = 0;
        got_done = 1'b0;
        got_err = 1'b0;
        while (n < 100 && !got_done && !got_err) begin
            @(negedge clk);
            n++;
            got_done = cfg_done;
            got_err  = cfg_err;
        end
        if (exp_ok) begin
            case (op)
                0: begin model[a] = b; model[b] = a; exp_cnt++; end
                1: begin p = model[a]; model[a] = a; model[p] = p; exp_cnt--; end
                default: begin
                    for (int i = 0; i < AL; i++) model[i] = i;
                    exp_cnt = 0;
                end
            endcase
        end
        $display("cfg %s op=%0d a=%0d b=%0d done=%0d err=%0d lat=%0d count=%0d",
                 tag, op, a, b, got_done, got_err, n, cable_count);
        check_eq({tag, " done"}, 32'(got_done), 32'(exp_ok));
        check_eq({tag, " err"}, 32'(got_err), 32'(!exp_ok));
        check_eq({tag, " latency"}, n, exp_lat);
        check_eq({tag, " cable_count"}, 32'(cable_count), exp_cnt);
        @(negedge clk);
        check_eq({tag, " single pulse"}, 32'(cfg_done | cfg_err), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("scoreboard drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   q[$];
        int   n;
        bit   got_done;
        exp_t held;

        for (int i = 0; i < AL; i++) model[i] = i;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset out_valid", 32'(out_valid), 0);
        check_eq("reset cable_count", 32'(cable_count), 0);
        check_eq("reset cfg_done", 32'(cfg_done), 0);
        check_eq("reset cfg_err", 32'(cfg_err), 0);
        check_eq("reset cfg_ready", 32'(cfg_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        q = '{0, 7, 25};
        send_list("identity", q);
        drain();

        cfg_run("plug 0-4", 0, 0, 4, 1'b1, 4);
        q = '{0, 4, 1};
        send_list("after plug", q);
        drain();

        cfg_run("plug 4-7 busy", 0, 4, 7, 1'b0, 2);
        cfg_run("plug 3-3 self", 0, 3, 3, 1'b0, 2);
        cfg_run("plug 26-1 range", 0, 26, 1, 1'b0, 2);
        q = '{0, 4, 7, 3};
        send_list("after rejects", q);
        drain();

        cfg_run("plug 1-2", 0, 1, 2, 1'b1, 4);
        cfg_run("plug 3-5", 0, 3, 5, 1'b1, 4);
        cfg_run("plug 6-8", 0, 6, 8, 1'b1, 4);
        cfg_run("plug 9-10", 0, 9, 10, 1'b1, 4);
        cfg_run("plug 11-12", 0, 11, 12, 1'b1, 4);
        cfg_run("plug 13-14", 0, 13, 14, 1'b1, 4);
        cfg_run("plug 15-16", 0, 15, 16, 1'b1, 4);
        cfg_run("plug 17-18", 0, 17, 18, 1'b1, 4);
        cfg_run("plug 19-22", 0, 19, 22, 1'b1, 4);
        cfg_run("plug 20-21 full", 0, 20, 21, 1'b0, 2);
        cfg_run("unplug 4", 1, 4, 9, 1'b1, 4);
        cfg_run("unplug 4 again", 1, 4, 0, 1'b0, 2);
        cfg_run("reserved op", 3, 1, 2, 1'b0, 2);
        q = '{0, 4, 1, 2, 19, 22, 20, 27, 31};
        send_list("full board", q);
        drain();

        cfg_run("clear", 2, 0, 0, 1'b1, 28);
        q = '{0, 1, 22, 4};
        send_list("after clear", q);
        drain();

        // Config and letter raised together: config must be taken first.
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_op    = 2'b00;
        cfg_a     = 5'd2;
        cfg_b     = 5'd3;
        in_valid  = 1'b1;
        in_letter = 5'd2;
        @(negedge clk);
        check_eq("prio cfg_ready", 32'(cfg_ready), 1);
        check_eq("prio in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        n = 0;
        got_done = 1'b0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
            if (cfg_done) got_done = 1'b1;
        end
        model[2] = 3;
        model[3] = 2;
        exp_cnt++;
        check_eq("prio cfg before letter", 32'(got_done), 1);
        exp_q.push_back(mk_exp(2));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("prio cable_count", 32'(cable_count), exp_cnt);
        drain();

        // Backpressure: result must hold, input blocked, config must not disturb it.
        out_ready = 1'b0;
        q = '{2};
        held = mk_exp(2);
        send_list("bp first", q);
        in_valid  = 1'b1;
        in_letter = 5'd9;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("bp out_valid c%0d", k), 32'(out_valid), 1);
            check_eq($sformatf("bp out_letter c%0d", k), 32'(out_letter), held.letter);
            check_eq($sformatf("bp in_ready c%0d", k), 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        cfg_run("unplug 2 during stall", 1, 2, 0, 1'b1, 4);
        check_eq("bp held after cfg", 32'(out_letter), held.letter);
        check_eq("bp valid after cfg", 32'(out_valid), 1);
        out_ready = 1'b1;
        q = '{2, 3};
        send_list("bp release", q);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
